param_mas_serializer: RTL and testbench

PARAM_MAS_SERIALIZER -- requirements
Module: param_mas_serializer

---
 rtl/param_mas_serializer_pkg.sv | 23 ++
 rtl/param_mas_serializer_ser_lane.sv | 102 ++++++++++
 rtl/param_mas_serializer.sv | 54 +++++
 tb/tb_param_mas_serializer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/param_mas_serializer_pkg.sv
// Shared definitions for the multi-lane serializer: frame geometry, line
// levels and the per-lane state encoding.
package param_mas_serializer_pkg;

  // First bit of every frame; marks the frame start on an idle-low line.
  localparam logic START_BIT = 1'b1;

  // Level driven on a lane's serial line while no frame is in flight.
  localparam logic IDLE_LVL  = 1'b0;

  // A lane is either waiting for a launch or shifting out a frame.
  typedef enum logic {
    LANE_IDLE = 1'b0,
    LANE_SEND = 1'b1
  } lane_state_e;

  // Total frame length in bits: start bit, payload, optional parity bit.
  function automatic int unsigned frame_len(input int unsigned w,
                                            input int unsigned parity_en);
    return 1 + w + ((parity_en != 0) ? 1 : 0);
  endfunction

endpackage : param_mas_serializer_pkg

// File: rtl/param_mas_serializer_ser_lane.sv
// Single serializer lane: captures a word on launch, then shifts out
// start bit, payload (MSB or LSB first) and optional even parity.
module ser_lane
  import param_mas_serializer_pkg::*;
#(
  parameter int unsigned W         = 8,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] word_i,
  input  logic         start_i,
  output logic         busy_o,
  output logic         serial_o,
  output logic         done_o
);

  localparam int unsigned L     = frame_len(W, PARITY_EN);
  localparam int unsigned CNT_W = $clog2(L + 1);

  lane_state_e      state_q, state_d;
  logic [L-1:0]     frame_q, frame_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             done_q,  done_d;

  logic [W-1:0]     payload;
  logic [L-1:0]     frame_new;
  logic             parity;

  // Assemble the outgoing frame from the live input word; the MSB of
  // frame_new is transmitted first.
  always_comb begin
    payload = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (MSB_FIRST != 0) begin
        payload[i] = word_i[i];
      end else begin
        payload[i] = word_i[W-1-i];
      end
    end
    parity           = ^word_i;
    frame_new        = '0;
    frame_new[L-1]   = START_BIT;
    frame_new[L-2 -: W] = payload;
    if (PARITY_EN != 0) begin
      frame_new[0] = parity;
    end
  end

  // Next-state logic: cnt_q holds the 1-based index of the bit on the line,
  // so reaching L means the last bit is out and the lane returns to idle.
  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      LANE_IDLE: begin
        if (start_i) begin
          state_d = LANE_SEND;
          frame_d = frame_new;
          cnt_d   = CNT_W'(1);
        end
      end
      LANE_SEND: begin
        if (cnt_q == CNT_W'(L)) begin
          state_d = LANE_IDLE;
          frame_d = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          frame_d = {frame_q[L-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LANE_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any frame silently.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LANE_IDLE;
      frame_q <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q == LANE_SEND);
  assign serial_o = busy_o ? frame_q[L-1] : IDLE_LVL;
  assign done_o   = done_q;

endmodule : ser_lane

// File: rtl/param_mas_serializer.sv
// Multi-lane serializer: lane 0 sends the command word, lanes 1..LANES
// send data words; every lane runs independently.
module param_mas_serializer
  import param_mas_serializer_pkg::*;
#(
  parameter int unsigned CMD_W     = 5,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LANES     = 1,
  parameter int unsigned PARITY_EN = 1,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [CMD_W-1:0]        command_i,
  input  logic [LANES*DATA_W-1:0] data_i,
  input  logic [LANES:0]          start_i,
  output logic [LANES:0]          lvds_busy,
  output logic [LANES:0]          serial_o,
  output logic [LANES:0]          done_o
);

  // Command lane.
  ser_lane #(
    .W         (CMD_W),
    .PARITY_EN (PARITY_EN),
    .MSB_FIRST (MSB_FIRST)
  ) u_cmd_lane (
    .clk      (clk),
    .reset    (reset),
    .word_i   (command_i),
    .start_i  (start_i[0]),
    .busy_o   (lvds_busy[0]),
    .serial_o (serial_o[0]),
    .done_o   (done_o[0])
  );

  // Data lanes; lane k takes slice (k-1) of data_i.
  for (genvar k = 1; k <= LANES; k++) begin : g_data_lane
    ser_lane #(
      .W         (DATA_W),
      .PARITY_EN (PARITY_EN),
      .MSB_FIRST (MSB_FIRST)
    ) u_data_lane (
      .clk      (clk),
      .reset    (reset),
      .word_i   (data_i[(k-1)*DATA_W +: DATA_W]),
      .start_i  (start_i[k]),
      .busy_o   (lvds_busy[k]),
      .serial_o (serial_o[k]),
      .done_o   (done_o[k])
    );
  end

endmodule : param_mas_serializer

// File: tb/tb_param_mas_serializer.sv
// Bench for param_mas_serializer: three configurations side by side, a
// frame-level reference model, per-cycle comparison and directed scenarios.
module tb_param_mas_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Global lane numbering: a = 0..1, b = 2..5, c = 6..7.
  logic [7:0]  st = '0;
  logic [4:0]  a_cmd = '0, b_cmd = '0, c_cmd = '0;
  logic [31:0] a_data = '0, c_data = '0;
  logic [23:0] b_data = '0;

  logic [1:0] a_busy, a_ser, a_done;
  logic [3:0] b_busy, b_ser, b_done;
  logic [1:0] c_busy, c_ser, c_done;
  logic [7:0] busy_all, ser_all, done_all;

  assign busy_all = {c_busy, b_busy, a_busy};
  assign ser_all  = {c_ser,  b_ser,  a_ser};
  assign done_all = {c_done, b_done, a_done};

  param_mas_serializer #(.CMD_W(5), .DATA_W(32), .LANES(1), .PARITY_EN(1), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset(rst), .command_i(a_cmd), .data_i(a_data), .start_i(st[1:0]),
    .lvds_busy(a_busy), .serial_o(a_ser), .done_o(a_done));

  param_mas_serializer #(.CMD_W(5), .DATA_W(8), .LANES(3), .PARITY_EN(0), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset(rst), .command_i(b_cmd), .data_i(b_data), .start_i(st[5:2]),
    .lvds_busy(b_busy), .serial_o(b_ser), .done_o(b_done));

  param_mas_serializer #(.CMD_W(5), .DATA_W(32), .LANES(1), .PARITY_EN(1), .MSB_FIRST(0)) dut_c (
    .clk(clk), .reset(rst), .command_i(c_cmd), .data_i(c_data), .start_i(st[7:6]),
    .lvds_busy(c_busy), .serial_o(c_ser), .done_o(c_done));

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-lane configuration as seen by the model.
  function automatic int lane_w(input int g);
    case (g)
      0, 2, 6: return 5;
      3, 4, 5: return 8;
      default: return 32;
    endcase
  endfunction
  function automatic int lane_p(input int g);
    return (g >= 2 && g <= 5) ? 0 : 1;
  endfunction
  function automatic int lane_m(input int g);
    return (g <= 1) ? 1 : 0;
  endfunction
  function automatic logic [31:0] word_of(input int g);
    case (g)
      0: return 32'(a_cmd);
      1: return a_data;
      2: return 32'(b_cmd);
      3: return 32'(b_data[7:0]);
      4: return 32'(b_data[15:8]);
      5: return 32'(b_data[23:16]);
      6: return 32'(c_cmd);
      default: return c_data;
    endcase
  endfunction

  // Reference model: each lane holds a list of frame bits and the index of
  // the bit currently on the line (-1 when idle).
  int mpos [8] = '{default: -1};
  int mlen [8] = '{default: 0};
  bit mfrm [8][41];
  bit mdone[8] = '{default: 1'b0};

  initial begin
    forever begin
      @(posedge clk);
      for (int g = 0; g < 8; g++) begin
        if (rst) begin
          mpos[g]  = -1;
          mdone[g] = 1'b0;
        end else if (mpos[g] < 0) begin
          mdone[g] = 1'b0;
          if (st[g]) begin
            logic [31:0] w;
            bit par;
            int wd;
            w = word_of(g);
            wd = lane_w(g);
            par = 1'b0;
            mfrm[g][0] = 1'b1;
            for (int i = 0; i < wd; i++) begin
              mfrm[g][1+i] = (lane_m(g) != 0) ? w[wd-1-i] : w[i];
              par ^= w[i];
            end
            if (lane_p(g) != 0) mfrm[g][wd+1] = par;
            mlen[g] = 1 + wd + lane_p(g);
            mpos[g] = 0;
          end
        end else if (mpos[g] == mlen[g] - 1) begin
          mpos[g]  = -1;
          mdone[g] = 1'b1;
        end else begin
          mpos[g]++;
          mdone[g] = 1'b0;
        end
      end
    end
  end

  // Compare every lane of every instance against the model each cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int g = 0; g < 8; g++) begin
          chk($sformatf("busy[%0d]", g), 64'(busy_all[g]), 64'(mpos[g] >= 0));
          chk($sformatf("serial[%0d]", g), 64'(ser_all[g]),
              64'((mpos[g] >= 0) ? mfrm[g][mpos[g]] : 1'b0));
          chk($sformatf("done[%0d]", g), 64'(done_all[g]), 64'(mdone[g]));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0]  got7;
    logic [33:0] got34;
    logic [8:0]  got9a, got9b;
    int busy_n, n_done0, n_done1;
    bit all_busy;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_busy", 64'(busy_all), 64'h0);
    chk("reset_serial", 64'(ser_all), 64'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Command frame 10110 with a start pulse ignored at t+3.
    a_cmd = 5'b10110;
    st[0] = 1'b1;
    got7 = '0;
    all_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      st[0] = (i == 3);
      a_cmd = 5'b01001;
      if (i <= 7) begin
        got7 = {got7[5:0], a_ser[0]};
        all_busy &= a_busy[0];
      end else begin
        chk("cmd_done_t8", 64'(a_done[0]), 64'h1);
        chk("cmd_busy_t8", 64'(a_busy[0]), 64'h0);
      end
      if (a_busy[1] || a_ser[1]) chk("lane1_idle", 64'({a_busy[1], a_ser[1]}), 64'h0);
    end
    st[0] = 1'b0;
    chk("cmd_bits", 64'(got7), 64'b1101101);
    chk("cmd_busy_span", 64'(all_busy), 64'h1);
    repeat (3) @(negedge clk);

    // LSB-first 32-bit data lane with parity.
    c_data = 32'h8000_0001;
    st[7] = 1'b1;
    got34 = '0;
    busy_n = 0;
    for (int i = 1; i <= 35; i++) begin
      @(negedge clk);
      st[7] = 1'b0;
      c_data = $urandom;
      if (i <= 34) got34 = {got34[32:0], c_ser[1]};
      busy_n += int'(c_busy[1]);
      if (i == 35) chk("data_done_t35", 64'(c_done[1]), 64'h1);
    end
    chk("data_bits", 64'(got34), 64'h3_0000_0002);
    chk("data_busy_len", 64'(busy_n), 64'd34);

    // Three 9-bit data lanes launched together, no parity, LSB first.
    b_data = {8'h5A, 8'h00, 8'hFF};
    st[5:3] = 3'b111;
    got9a = '0;
    got9b = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      st[5:3] = 3'b000;
      b_data = 24'($urandom);
      if (i <= 9) begin
        got9a = {got9a[7:0], b_ser[1]};
        got9b = {got9b[7:0], b_ser[3]};
      end else begin
        chk("b_done_same", 64'(b_done[3:1]), 64'b111);
      end
    end
    chk("b_lane1_bits", 64'(got9a), 64'h1FF);
    chk("b_lane3_bits", 64'(got9b), 64'b1_0101_1010);

    // Reset in the middle of a data frame, then relaunch straight after.
    a_data = $urandom;
    st[1] = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      st[1] = 1'b0;
      a_data = $urandom;
      if (i == 4) rst = 1'b1;
      if (i == 5) begin
        chk("rst_abort_busy", 64'(a_busy[1]), 64'h0);
        chk("rst_abort_done", 64'(a_done[1]), 64'h0);
        rst = 1'b0;
        st[1] = 1'b1;
      end
    end
    @(negedge clk);
    st[1] = 1'b0;
    chk("relaunch_busy", 64'(a_busy[1]), 64'h1);
    repeat (40) @(negedge clk);

    // Starts held high on every lane for 100 cycles with changing inputs.
    st = 8'hFF;
    n_done0 = 0;
    n_done1 = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      a_cmd = 5'($urandom); a_data = $urandom;
      b_cmd = 5'($urandom); b_data = 24'($urandom);
      c_cmd = 5'($urandom); c_data = $urandom;
      n_done0 += int'(a_done[0]);
      n_done1 += int'(a_done[1]);
    end
    st = '0;
    chk("held_cmd_frames", 64'(n_done0), 64'd12);
    chk("held_data_frames", 64'(n_done1), 64'd2);
    repeat (40) @(negedge clk);

    // Random traffic with sparse resets.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      for (int g = 0; g < 8; g++) st[g] = ($urandom_range(3) == 0);
      a_cmd = 5'($urandom); a_data = $urandom;
      b_cmd = 5'($urandom); b_data = 24'($urandom);
      c_cmd = 5'($urandom); c_data = $urandom;
      rst = ($urandom_range(299) == 0);
    end
    st = '0;
    rst = 1'b0;
    repeat (40) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule : tb_param_mas_serializer
